// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: variable-length multicycle MIPS control unit.
// Each instruction class walks only the states it needs, and memory
// states wait on the mem_ready handshake.
// Optional feature macro: CTRL_OVF_TRAP_EN. When it is defined, a signed
// overflow on add/sub/addi traps to the exception vector instead of
// writing back the result.
module multicycle_ctrl_fsm #(
  parameter int OP_W     = 6,
  parameter int FUNCT_W  = 6,
  parameter int ALUOP_W  = 3,
  parameter int IDLE_CYC = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               zero,
  input  logic               neg,
  input  logic               ovf,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               ir_write,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [2:0]         state,
  output logic               instr_done,
  output logic               illegal,
  output logic               exc
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_IDLE   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_ILLEGAL,
    C_RALU,
    C_JR,
    C_ADDI,
    C_ANDI,
    C_LW,
    C_SW,
    C_BEQ,
    C_BNE,
    C_BGTZ,
    C_J
  } class_t;

  localparam logic [1:0] PC_SEQ  = 2'd0;
  localparam logic [1:0] PC_BR   = 2'd1;
  localparam logic [1:0] PC_JMP  = 2'd2;
  localparam logic [1:0] PC_EXC  = 2'd3;

  localparam logic [1:0] SRCB_RT   = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_SEXT = 2'd2;
  localparam logic [1:0] SRCB_ZEXT = 2'd3;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_XOR = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_NOR = ALUOP_W'(5);

  localparam int IDLE_W = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYC - 1);

  state_t               state_q;
  state_t               state_nxt;
  logic [OP_W-1:0]      op_q;
  logic [FUNCT_W-1:0]   funct_q;
  logic [IDLE_W-1:0]    idle_cnt;
  class_t               cls_live;
  class_t               cls_lat;
  logic                 trap_hit;

  // Map an op/funct pair onto the instruction class that selects the state path.
  function automatic class_t classify(input logic [OP_W-1:0] o,
                                      input logic [FUNCT_W-1:0] f);
    class_t c;
    c = C_ILLEGAL;
    case (o)
      OP_W'(0): begin
        if (f == FUNCT_W'(8))
          c = C_JR;
        else if ((f >= FUNCT_W'(32)) && (f <= FUNCT_W'(39)))
          c = C_RALU;
        else
          c = C_ILLEGAL;
      end
      OP_W'(2):  c = C_J;
      OP_W'(4):  c = C_BEQ;
      OP_W'(5):  c = C_BNE;
      OP_W'(7):  c = C_BGTZ;
      OP_W'(8):  c = C_ADDI;
      OP_W'(12): c = C_ANDI;
      OP_W'(35): c = C_LW;
      OP_W'(43): c = C_SW;
      default:   c = C_ILLEGAL;
    endcase
    return c;
  endfunction

  // ALU function for the eight supported R-type arithmetic/logic funct codes.
  function automatic logic [ALUOP_W-1:0] r_alu_op(input logic [FUNCT_W-1:0] f);
    logic [ALUOP_W-1:0] a;
    case (f)
      FUNCT_W'(32), FUNCT_W'(33): a = ALU_ADD;
      FUNCT_W'(34), FUNCT_W'(35): a = ALU_SUB;
      FUNCT_W'(36):               a = ALU_AND;
      FUNCT_W'(37):               a = ALU_OR;
      FUNCT_W'(38):               a = ALU_XOR;
      FUNCT_W'(39):               a = ALU_NOR;
      default:                    a = ALU_ADD;
    endcase
    return a;
  endfunction

  // DECODE looks at the live IR fields; later states use the copy latched in DECODE.
  assign cls_live = classify(op, funct);
  assign cls_lat  = classify(op_q, funct_q);
  assign state    = state_q;

`ifdef CTRL_OVF_TRAP_EN
  // Only the signed adds/subtracts trap; addu/subu never do.
  assign trap_hit = ovf && ((cls_lat == C_ADDI) ||
                            ((cls_lat == C_RALU) &&
                             ((funct_q == FUNCT_W'(32)) || (funct_q == FUNCT_W'(34)))));
`else
  logic ovf_unused;
  assign ovf_unused = ovf;
  assign trap_hit   = 1'b0;
`endif

  // State register; reset drops straight into IDLE, abandoning any access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= S_IDLE;
    else
      state_q <= state_nxt;
  end

  // Capture op/funct at the end of DECODE so EXEC/MEM/WB see a stable copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      funct_q <= '0;
    end else if (state_q == S_DECODE) begin
      op_q    <= op;
      funct_q <= funct;
    end
  end

  // Count the cycles spent in IDLE after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      idle_cnt <= '0;
    else if (state_q == S_IDLE)
      idle_cnt <= idle_cnt + 1'b1;
    else
      idle_cnt <= '0;
  end

  // Next-state selection and datapath strobes for the current state.
  always_comb begin
    state_nxt  = state_q;
    pc_write   = 1'b0;
    pc_src     = PC_SEQ;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_op     = ALU_ADD;
    instr_done = 1'b0;
    illegal    = 1'b0;
    exc        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (idle_cnt == IDLE_LAST)
          state_nxt = S_FETCH;
      end

      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALU_ADD;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          pc_src    = PC_SEQ;
          state_nxt = S_DECODE;
        end
      end

      S_DECODE: begin
        case (cls_live)
          C_ILLEGAL: begin
            illegal    = 1'b1;
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
          end
          C_J: begin
            pc_write   = 1'b1;
            pc_src     = PC_JMP;
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
          end
          default: state_nxt = S_EXEC;
        endcase
      end

      S_EXEC: begin
        case (cls_lat)
          C_RALU: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_RT;
            alu_op    = r_alu_op(funct_q);
            state_nxt = S_WB;
          end
          C_ADDI: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_SEXT;
            alu_op    = ALU_ADD;
            state_nxt = S_WB;
          end
          C_ANDI: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_ZEXT;
            alu_op    = ALU_AND;
            state_nxt = S_WB;
          end
          C_LW, C_SW: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_SEXT;
            alu_op    = ALU_ADD;
            state_nxt = S_MEM;
          end
          C_BEQ, C_BNE, C_BGTZ: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_RT;
            alu_op     = ALU_SUB;
            pc_src     = PC_BR;
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
            if (cls_lat == C_BEQ)
              pc_write = zero;
            else if (cls_lat == C_BNE)
              pc_write = !zero;
            else
              pc_write = !zero && !neg;
          end
          C_JR: begin
            pc_write   = 1'b1;
            pc_src     = PC_JMP;
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
          end
          default: state_nxt = S_FETCH;
        endcase
        if (trap_hit) begin
          exc        = 1'b1;
          pc_write   = 1'b1;
          pc_src     = PC_EXC;
          instr_done = 1'b1;
          state_nxt  = S_FETCH;
        end
      end

      S_MEM: begin
        iord = 1'b1;
        if (cls_lat == C_SW) begin
          mem_write = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
          end
        end else begin
          mem_read = 1'b1;
          if (mem_ready)
            state_nxt = S_WB;
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
        if (cls_lat == C_LW) begin
          mem_to_reg = 1'b1;
          reg_dst    = 1'b0;
        end else begin
          reg_dst = (cls_lat == C_RALU);
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: directed and randomized checks of the multicycle
// control FSM against a per-instruction cycle-sequence model.
module tb_multicycle_ctrl_fsm;

  localparam int IDLE_CYC = 1;

  localparam int K_ILL  = 0;
  localparam int K_R    = 1;
  localparam int K_JR   = 2;
  localparam int K_ADDI = 3;
  localparam int K_ANDI = 4;
  localparam int K_LW   = 5;
  localparam int K_SW   = 6;
  localparam int K_BEQ  = 7;
  localparam int K_BNE  = 8;
  localparam int K_BGTZ = 9;
  localparam int K_J    = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       neg = 1'b0;
  logic       ovf = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       ir_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [2:0] state;
  logic       instr_done;
  logic       illegal;
  logic       exc;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [2:0] state;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       instr_done;
    logic       illegal;
    logic       exc;
  } out_t;

  typedef struct {
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       neg;
    logic       ovf;
    logic       mem_ready;
    out_t       exp;
    int         instr_id;
  } cyc_t;

  cyc_t cyc_q[$];
  out_t obs;
  int   r_alu_tbl[8] = '{0, 0, 1, 1, 2, 3, 4, 5};

  assign obs = {state, pc_write, pc_src, ir_write, iord, mem_read, mem_write,
                reg_write, mem_to_reg, reg_dst, alu_src_a, alu_src_b, alu_op,
                instr_done, illegal, exc};

  multicycle_ctrl_fsm #(
    .OP_W(6), .FUNCT_W(6), .ALUOP_W(3), .IDLE_CYC(IDLE_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .neg(neg),
    .ovf(ovf), .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
    .ir_write(ir_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state),
    .instr_done(instr_done), .illegal(illegal), .exc(exc)
  );

  // Free-running clock, rising edge at 5 + 10n.
  always #5 clk = ~clk;

  function automatic int kind_of(input logic [5:0] o, input logic [5:0] f);
    int k;
    k = K_ILL;
    if (o == 6'd0) begin
      if (f == 6'd8) k = K_JR;
      else if (f >= 6'd32 && f <= 6'd39) k = K_R;
    end else if (o == 6'd2)  k = K_J;
    else if (o == 6'd4)  k = K_BEQ;
    else if (o == 6'd5)  k = K_BNE;
    else if (o == 6'd7)  k = K_BGTZ;
    else if (o == 6'd8)  k = K_ADDI;
    else if (o == 6'd12) k = K_ANDI;
    else if (o == 6'd35) k = K_LW;
    else if (o == 6'd43) k = K_SW;
    return k;
  endfunction

  // One cycle with don't-care inputs randomized and every strobe expected low.
  function automatic cyc_t blank(input logic [2:0] st, input logic [5:0] o,
                                 input logic [5:0] f, input int id);
    cyc_t c;
    c.rst_n     = 1'b1;
    c.op        = o;
    c.funct     = f;
    c.zero      = 1'($urandom_range(0, 1));
    c.neg       = 1'($urandom_range(0, 1));
    c.ovf       = 1'($urandom_range(0, 1));
    c.mem_ready = 1'($urandom_range(0, 1));
    c.exp       = '0;
    c.exp.state = st;
    c.instr_id  = id;
    return c;
  endfunction

  // Queue the reset/IDLE cycles: everything low, state reads 7.
  task automatic push_idle(input logic rst_val, input int n, input int id);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = blank(3'd7, 6'($urandom), 6'($urandom), id);
      c.rst_n = rst_val;
      cyc_q.push_back(c);
    end
  endtask

  // Expand one instruction into its expected cycle-by-cycle behaviour.
  task automatic build_instr(input logic [5:0] o, input logic [5:0] f,
                             input int fw, input int mw, input logic z,
                             input logic n, input logic v, input int id);
    cyc_t c;
    int   k;
    logic trap;
    k = kind_of(o, f);
    for (int w = 0; w <= fw; w++) begin
      c = blank(3'd0, 6'($urandom), 6'($urandom), id);
      c.mem_ready = (w == fw);
      c.exp.mem_read  = 1'b1;
      c.exp.alu_src_b = 2'd1;
      if (w == fw) begin
        c.exp.ir_write = 1'b1;
        c.exp.pc_write = 1'b1;
      end
      cyc_q.push_back(c);
    end
    c = blank(3'd1, o, f, id);
    if (k == K_ILL) begin
      c.exp.illegal = 1'b1;
      c.exp.instr_done = 1'b1;
      cyc_q.push_back(c);
      return;
    end
    if (k == K_J) begin
      c.exp.pc_write = 1'b1;
      c.exp.pc_src = 2'd2;
      c.exp.instr_done = 1'b1;
      cyc_q.push_back(c);
      return;
    end
    cyc_q.push_back(c);
    c = blank(3'd2, o, f, id);
    c.zero = z;
    c.neg  = n;
    c.ovf  = v;
    trap = 1'b0;
`ifdef CTRL_OVF_TRAP_EN
    trap = v && (k == K_ADDI || (k == K_R && (f == 6'd32 || f == 6'd34)));
`endif
    if (k == K_R) begin
      c.exp.alu_src_a = 1'b1;
      c.exp.alu_op = 3'(r_alu_tbl[int'(f) - 32]);
    end else if (k == K_ADDI || k == K_LW || k == K_SW) begin
      c.exp.alu_src_a = 1'b1;
      c.exp.alu_src_b = 2'd2;
    end else if (k == K_ANDI) begin
      c.exp.alu_src_a = 1'b1;
      c.exp.alu_src_b = 2'd3;
      c.exp.alu_op = 3'd2;
    end else if (k == K_BEQ || k == K_BNE || k == K_BGTZ) begin
      c.exp.alu_src_a = 1'b1;
      c.exp.alu_op = 3'd1;
      c.exp.pc_src = 2'd1;
      c.exp.instr_done = 1'b1;
      c.exp.pc_write = (k == K_BEQ) ? z : (k == K_BNE) ? !z : (!z && !n);
    end else if (k == K_JR) begin
      c.exp.pc_write = 1'b1;
      c.exp.pc_src = 2'd2;
      c.exp.instr_done = 1'b1;
    end
    if (trap) begin
      c.exp.exc = 1'b1;
      c.exp.pc_write = 1'b1;
      c.exp.pc_src = 2'd3;
      c.exp.instr_done = 1'b1;
    end
    cyc_q.push_back(c);
    if (trap || k == K_BEQ || k == K_BNE || k == K_BGTZ || k == K_JR) return;
    if (k == K_LW || k == K_SW) begin
      for (int w = 0; w <= mw; w++) begin
        c = blank(3'd3, o, f, id);
        c.mem_ready = (w == mw);
        c.exp.iord = 1'b1;
        if (k == K_LW) c.exp.mem_read = 1'b1;
        else c.exp.mem_write = 1'b1;
        if (k == K_SW && w == mw) c.exp.instr_done = 1'b1;
        cyc_q.push_back(c);
      end
      if (k == K_SW) return;
    end
    c = blank(3'd4, o, f, id);
    c.exp.reg_write = 1'b1;
    c.exp.instr_done = 1'b1;
    if (k == K_LW) c.exp.mem_to_reg = 1'b1;
    else c.exp.reg_dst = (k == K_R);
    cyc_q.push_back(c);
  endtask

  task automatic applyStimulus(input cyc_t c);
    @(negedge clk);
    rst_n     = c.rst_n;
    op        = c.op;
    funct     = c.funct;
    zero      = c.zero;
    neg       = c.neg;
    ovf       = c.ovf;
    mem_ready = c.mem_ready;
    #1;
  endtask

  task automatic checkOutput(input string tag, input out_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h (state obs=%0d exp=%0d)",
             tag, obs, exp, obs.state, exp.state);
    end
  endtask

  task automatic run_one();
    cyc_t c;
    c = cyc_q.pop_front();
    applyStimulus(c);
    checkOutput($sformatf("instr%0d_state%0d", c.instr_id, c.exp.state), c.exp);
  endtask

  task automatic run_queue();
    while (cyc_q.size() > 0) run_one();
  endtask

  initial begin
    out_t       zero_exp;
    logic [5:0] ro;
    logic [5:0] rf;
    int         id;

    $display("[TB] reset and directed instructions");
    id = 0;
    push_idle(1'b0, 2, id);
    push_idle(1'b1, IDLE_CYC, id);
    id++; build_instr(6'd0,  6'd32, 0, 0, 1'b0, 1'b0, 1'b0, id);
    id++; build_instr(6'd35, 6'd17, 0, 3, 1'b0, 1'b0, 1'b0, id);
    id++; build_instr(6'd5,  6'd0,  1, 0, 1'b0, 1'b0, 1'b0, id);
    id++; build_instr(6'd5,  6'd0,  0, 0, 1'b1, 1'b0, 1'b0, id);
    id++; build_instr(6'd7,  6'd0,  0, 0, 1'b0, 1'b1, 1'b0, id);
    id++; build_instr(6'd7,  6'd0,  0, 0, 1'b0, 1'b0, 1'b0, id);
    id++; build_instr(6'd4,  6'd0,  0, 0, 1'b1, 1'b0, 1'b0, id);
    id++; build_instr(6'h3F, 6'd0,  0, 0, 1'b0, 1'b0, 1'b0, id);
    id++; build_instr(6'd8,  6'd5,  0, 0, 1'b0, 1'b0, 1'b1, id);
    id++; build_instr(6'd0,  6'd33, 0, 0, 1'b0, 1'b0, 1'b1, id);
    id++; build_instr(6'd0,  6'd34, 2, 0, 1'b0, 1'b0, 1'b1, id);
    id++; build_instr(6'd0,  6'd39, 0, 0, 1'b0, 1'b0, 1'b0, id);
    id++; build_instr(6'd12, 6'd9,  0, 0, 1'b0, 1'b0, 1'b0, id);
    id++; build_instr(6'd2,  6'd1,  0, 0, 1'b0, 1'b0, 1'b0, id);
    id++; build_instr(6'd0,  6'd8,  0, 0, 1'b0, 1'b0, 1'b0, id);
    id++; build_instr(6'd43, 6'd3,  0, 2, 1'b0, 1'b0, 1'b0, id);
    id++; build_instr(6'd0,  6'd0,  0, 0, 1'b0, 1'b0, 1'b0, id);
    run_queue();

    $display("[TB] reset asserted during store access");
    id++; build_instr(6'd43, 6'd0, 0, 3, 1'b0, 1'b0, 1'b0, id);
    while (cyc_q.size() > 0 && cyc_q[0].exp.state != 3'd3) run_one();
    run_one();
    cyc_q.delete();
    #2 rst_n = 1'b0;
    #1;
    zero_exp = '0;
    zero_exp.state = 3'd7;
    checkOutput("async_reset_in_mem", zero_exp);
    push_idle(1'b0, 1, id);
    push_idle(1'b1, IDLE_CYC, id);
    id++; build_instr(6'd0, 6'd36, 0, 0, 1'b0, 1'b0, 1'b0, id);
    run_queue();

    $display("[TB] randomized instruction stream");
    for (int i = 0; i < 60; i++) begin
      rf = 6'($urandom);
      case ($urandom_range(0, 13))
        0, 1:    begin ro = 6'd0; rf = 6'(32 + $urandom_range(0, 7)); end
        2:       begin ro = 6'd0; rf = 6'd8; end
        3:       ro = 6'd8;
        4:       ro = 6'd12;
        5:       ro = 6'd35;
        6:       ro = 6'd43;
        7:       ro = 6'd4;
        8:       ro = 6'd5;
        9:       ro = 6'd7;
        10:      ro = 6'd2;
        11:      ro = 6'($urandom);
        default: begin ro = 6'd0; rf = 6'($urandom_range(0, 31)); end
      endcase
      id++;
      build_instr(ro, rf, $urandom_range(0, 2), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), id);
      run_queue();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
